// File: rtl/fsmd_seq_dp.sv
// ============================================================================
// Module   : fsmd_seq_dp
// Purpose  : Six-state FSM with datapath computing
//              y1 = (a+b+c)*e   and   y2 = (a+b+c)*(c+d)
//            over three shared internal registers R1/R2/R3.
// Ports    : clock, reset (async, active-high), start,
//            a..e   [WIDTH-1:0] operands, captured on the accept edge,
//            busy, done (1-cycle pulse), y1/y2 [OUT_W-1:0], ovf, state[2:0].
// Macro    : FSMD_SAT_EN - when defined, results saturate to 2^OUT_W-1 and
//            ovf reports it; otherwise results wrap modulo 2^OUT_W, ovf = 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsmd_seq_dp #(
  parameter int WIDTH = 4,
  parameter int OUT_W = 2*WIDTH+3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] y1,
  output logic [OUT_W-1:0] y2,
  output logic             ovf,
  output logic [2:0]       state
);

  localparam int RW = 2*WIDTH+3;   // internal register width, never overflows
  localparam int PW = 2*RW;        // full product width for the y1 multiply

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD1 = 3'd1;
  localparam logic [2:0] S_ADD2 = 3'd2;
  localparam logic [2:0] S_ADD3 = 3'd3;
  localparam logic [2:0] S_MUL1 = 3'd4;
  localparam logic [2:0] S_MUL2 = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [RW-1:0]    r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [WIDTH-1:0] hb_q, hb_d, hd_q, hd_d, he_q, he_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [OUT_W-1:0] y1_q, y1_d, y2_q, y2_d;
  logic [OUT_W-1:0] y1_res, y2_res;

  // Result width adaptation applied at the MUL2 load.
`ifdef FSMD_SAT_EN
  logic [PW-1:0] p13;
  logic          sat1, sat2;
  logic          ovf_q, ovf_d;

  assign p13    = PW'(r1_q) * PW'(r3_q);
  assign sat1   = (p13 >> OUT_W) != '0;
  assign sat2   = (r2_q >> OUT_W) != '0;
  assign y1_res = sat1 ? {OUT_W{1'b1}} : p13[OUT_W-1:0];
  assign y2_res = sat2 ? {OUT_W{1'b1}} : r2_q[OUT_W-1:0];
  assign ovf    = ovf_q;
`else
  // Low bits of a product do not depend on the upper operand bits, so an
  // OUT_W-wide product is exactly the modulo-2^OUT_W result.
  assign y1_res = OUT_W'(r1_q * r3_q);
  assign y2_res = r2_q[OUT_W-1:0];
  assign ovf    = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; unused codes 6/7 fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_ADD1 : S_IDLE;
      S_ADD1:  state_d = S_ADD2;
      S_ADD2:  state_d = S_ADD3;
      S_ADD3:  state_d = S_MUL1;
      S_MUL1:  state_d = S_MUL2;
      S_MUL2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values. Everything holds by default, so the
  // illegal codes and idle-without-start leave all registers untouched.
  always_comb begin
    r1_d   = r1_q;
    r2_d   = r2_q;
    r3_d   = r3_q;
    hb_d   = hb_q;
    hd_d   = hd_q;
    he_d   = he_q;
    busy_d = busy_q;
    done_d = 1'b0;
    y1_d   = y1_q;
    y2_d   = y2_q;
`ifdef FSMD_SAT_EN
    ovf_d  = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          r1_d   = RW'(a);
          r2_d   = RW'(c);
          hb_d   = b;
          hd_d   = d;
          he_d   = e;
          busy_d = 1'b1;
        end
      end
      S_ADD1: begin            // R1 = a+c, R3 = d
        r1_d = r1_q + r2_q;
        r3_d = RW'(hd_q);
      end
      S_ADD2: begin            // R2 = c+d, R3 = b
        r2_d = r2_q + r3_q;
        r3_d = RW'(hb_q);
      end
      S_ADD3: begin            // R1 = a+b+c, R3 = e
        r1_d = r1_q + r3_q;
        r3_d = RW'(he_q);
      end
      S_MUL1: begin            // R2 = (a+b+c)*(c+d); fits RW bits exactly
        r2_d = r1_q * r2_q;
      end
      S_MUL2: begin
        y1_d   = y1_res;
        y2_d   = y2_res;
        done_d = 1'b1;
        busy_d = 1'b0;
`ifdef FSMD_SAT_EN
        ovf_d  = sat1 | sat2;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r1_q   <= '0;
      r2_q   <= '0;
      r3_q   <= '0;
      hb_q   <= '0;
      hd_q   <= '0;
      he_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      y1_q   <= '0;
      y2_q   <= '0;
`ifdef FSMD_SAT_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      r3_q   <= r3_d;
      hb_q   <= hb_d;
      hd_q   <= hd_d;
      he_q   <= he_d;
      busy_q <= busy_d;
      done_q <= done_d;
      y1_q   <= y1_d;
      y2_q   <= y2_d;
`ifdef FSMD_SAT_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign y1    = y1_q;
  assign y2    = y2_q;
  assign state = state_q;

endmodule

`default_nettype wire
